// File: rtl/nios_mtl_sysid_pkg.sv
// +-----------------------------------------------------------------------+
// | nios_mtl_sysid_pkg : register map and CTRL bit positions for sysid    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package nios_mtl_sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL      = 3'd4;
  localparam logic [2:0] ADDR_SCRATCH0  = 3'd5;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_FREEZE = 1;

endpackage

`default_nettype wire

// File: rtl/nios_mtl_sysid_uptime.sv
// +-----------------------------------------------------------------------+
// | nios_mtl_sysid_uptime : 64-bit uptime counter, freeze control, HI     |
// | shadow captured on UPTIME_LO reads.                     Rev 1.0       |
// +-----------------------------------------------------------------------+
`default_nettype none

module nios_mtl_sysid_uptime (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_ctrl_we,
  input  logic        i_clear,
  input  logic        i_freeze,
  input  logic        i_capture,
  output logic [31:0] o_count_lo,
  output logic [31:0] o_shadow_hi,
  output logic        o_freeze
);

  logic [63:0] r_count;
  logic [31:0] r_shadow;
  logic        r_freeze;

  // Counting uses the freeze value in force before this write lands.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_shadow <= '0;
      r_freeze <= 1'b0;
    end else begin
      if (i_ctrl_we && i_clear)
        r_count <= '0;
      else if (!r_freeze)
        r_count <= r_count + 64'd1;
      if (i_ctrl_we)
        r_freeze <= i_freeze;
      if (i_capture)
        r_shadow <= r_count[63:32];
    end
  end

  assign o_count_lo  = r_count[31:0];
  assign o_shadow_hi = r_shadow;
  assign o_freeze    = r_freeze;

endmodule

`default_nettype wire

// File: rtl/nios_mtl_sysid_ext.sv
// +-----------------------------------------------------------------------+
// | nios_mtl_sysid_ext : Avalon-MM system ID with scratch registers and   |
// | optional uptime counter (NIOS_MTL_SYSID_UPTIME_EN).     Rev 1.0       |
// +-----------------------------------------------------------------------+
`default_nettype none

module nios_mtl_sysid_ext
  import nios_mtl_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
  parameter int          NUM_SCRATCH     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [3:0] c_scratch_base = {1'b0, ADDR_SCRATCH0};

  logic [31:0] r_scratch [NUM_SCRATCH];
  logic [31:0] r_readdata;
  logic        r_readdatavalid;
  logic [3:0]  w_addr_ext;
  logic [31:0] w_rd_data;
  logic [31:0] w_uptime_lo;
  logic [31:0] w_uptime_hi;
  logic        w_freeze;

  // Widened address keeps a 4th scratch (index 8) from aliasing onto ID.
  assign w_addr_ext = {1'b0, address};

`ifdef NIOS_MTL_SYSID_UPTIME_EN
  logic w_ctrl_we;
  logic w_lo_capture;

  assign w_ctrl_we    = write && (address == ADDR_CTRL);
  assign w_lo_capture = read && (address == ADDR_UPTIME_LO);

  if (1) begin : g_uptime
    nios_mtl_sysid_uptime u_uptime (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_ctrl_we   (w_ctrl_we),
      .i_clear     (writedata[CTRL_CLEAR]),
      .i_freeze    (writedata[CTRL_FREEZE]),
      .i_capture   (w_lo_capture),
      .o_count_lo  (w_uptime_lo),
      .o_shadow_hi (w_uptime_hi),
      .o_freeze    (w_freeze)
    );
  end
`else
  assign w_uptime_lo = '0;
  assign w_uptime_hi = '0;
  assign w_freeze    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        r_scratch[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (write && (w_addr_ext == c_scratch_base + 4'(i)))
          r_scratch[i] <= writedata;
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (address)
      ADDR_ID:        w_rd_data = ID_VALUE;
      ADDR_TIMESTAMP: w_rd_data = TIMESTAMP_VALUE;
      ADDR_UPTIME_LO: w_rd_data = w_uptime_lo;
      ADDR_UPTIME_HI: w_rd_data = w_uptime_hi;
      ADDR_CTRL:      w_rd_data[CTRL_FREEZE] = w_freeze;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++)
          if (w_addr_ext == c_scratch_base + 4'(i))
            w_rd_data = r_scratch[i];
      end
    endcase
  end

  // Data is forced to zero whenever it is not qualified by readdatavalid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdata      <= read ? w_rd_data : 32'h0;
      r_readdatavalid <= read;
    end
  end

  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;

endmodule

`default_nettype wire

// File: tb/tb_nios_mtl_sysid_ext.sv
// Self-checking bench for nios_mtl_sysid_ext: fixed vector table, corner sequences,
// and randomized traffic against a register-map reference model.
`default_nettype none

module tb_nios_mtl_sysid_ext;

  localparam logic [31:0] ID_V = 32'h56FB_CAEB;
  localparam logic [31:0] TS_V = 32'h1357_9BDF;
  localparam int          NS   = 2;
`ifdef NIOS_MTL_SYSID_UPTIME_EN
  localparam bit UPTIME_EN = 1'b1;
`else
  localparam bit UPTIME_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_vec = 0;
  int n_err = 0;

  nios_mtl_sysid_ext #(
    .ID_VALUE        (ID_V),
    .TIMESTAMP_VALUE (TS_V),
    .NUM_SCRATCH     (NS)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [63:0] m_cnt = '0;
  logic [31:0] m_shadow = '0;
  logic        m_freeze = 1'b0;
  logic [31:0] m_scr [4];
  logic        m_rdv = 1'b0;
  logic [31:0] m_rd = '0;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    int ia;
    ia = int'(a);
    if (ia == 0) return ID_V;
    if (ia == 1) return TS_V;
    if (ia == 2) return UPTIME_EN ? m_cnt[31:0] : 32'h0;
    if (ia == 3) return UPTIME_EN ? m_shadow : 32'h0;
    if (ia == 4) return (UPTIME_EN && m_freeze) ? 32'h2 : 32'h0;
    if (ia >= 5 && ia < 5 + NS) return m_scr[ia - 5];
    return 32'h0;
  endfunction

  task automatic model_edge(input logic rn, input logic rd, input logic wr,
                            input logic [2:0] a, input logic [31:0] d);
    logic [31:0] v;
    int ia;
    v  = model_read(a);
    ia = int'(a);
    if (!rn) begin
      m_cnt = '0; m_shadow = '0; m_freeze = 1'b0; m_rdv = 1'b0; m_rd = '0;
      for (int i = 0; i < 4; i++) m_scr[i] = '0;
    end else begin
      m_rdv = rd;
      m_rd  = rd ? v : 32'h0;
      if (UPTIME_EN) begin
        if (rd && ia == 2) m_shadow = m_cnt[63:32];
        if (wr && ia == 4 && d[0]) m_cnt = 64'd0;
        else if (!m_freeze) m_cnt = m_cnt + 64'd1;
        if (wr && ia == 4) m_freeze = d[1];
      end
      if (wr && ia >= 5 && ia < 5 + NS) m_scr[ia - 5] = d;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive, advance model at the edge, compare shortly after.
  task automatic step(input logic rn, input logic rd, input logic wr,
                      input logic [2:0] a, input logic [31:0] d);
    reset_n = rn; read = rd; write = wr; address = a; writedata = d;
    @(posedge clock);
    model_edge(rn, rd, wr, a, d);
    #1;
    check("model_rdv", 32'(readdatavalid), 32'(m_rdv));
    check("model_rdata", readdata, m_rd);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic        exp_rdv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] ctrl_rb;
    int guard;
    ctrl_rb = UPTIME_EN ? 32'h2 : 32'h0;
    for (int i = 0; i < 4; i++) m_scr[i] = '0;

    vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,         1'b1, ID_V};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'd1, 32'h0,         1'b1, TS_V};
    vecs[3]  = '{1'b1, 1'b1, 3'd5, 32'hA5A5_5A5A, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'd5, 32'h0,         1'b1, 32'hA5A5_5A5A};
    vecs[5]  = '{1'b0, 1'b1, 3'd6, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 3'd6, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'd0, 32'h0,         1'b1, ID_V};
    vecs[9]  = '{1'b0, 1'b1, 3'd7, 32'h1234_5678, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'd7, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 3'd1, 32'h0,         1'b1, TS_V};
    vecs[12] = '{1'b1, 1'b0, 3'd4, 32'h0,         1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 3'd4, 32'hFFFF_FFFE, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 3'd4, 32'h0,         1'b1, ctrl_rb};
    vecs[15] = '{1'b0, 1'b1, 3'd4, 32'h0,         1'b0, 32'h0};

    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    check("reset_rdv", 32'(readdatavalid), 32'h0);
    check("reset_rdata", readdata, 32'h0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      step(1'b1, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d_rdv", i), 32'(readdatavalid), 32'(vecs[i].exp_rdv));
      check($sformatf("vec%0d_rdata", i), readdata, vecs[i].exp_rd);
    end

    // Clear+freeze at count 1000, then release the freeze
    guard = 0;
    while (UPTIME_EN && m_cnt != 64'd1000 && guard < 3000) begin
      step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
      guard++;
    end
    check("cnt_reach_1000_budget", 32'(guard < 3000), 32'h1);
    step(1'b1, 1'b0, 1'b1, 3'd4, 32'h3);
    repeat (10) step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd2, 32'h0);
    check("frozen_lo", readdata, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd3, 32'h0);
    check("frozen_hi", readdata, 32'h0);
    step(1'b1, 1'b0, 1'b1, 3'd4, 32'h0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd2, 32'h0);
    check("resumed_lo", readdata, UPTIME_EN ? 32'd5 : 32'd0);

`ifdef NIOS_MTL_SYSID_UPTIME_EN
    // 64-bit wrap and HI shadow capture
    force dut.g_uptime.u_uptime.r_count = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.g_uptime.u_uptime.r_count;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    repeat (2) step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd2, 32'h0);
    check("wrap_lo", readdata, 32'h0);
    force dut.g_uptime.u_uptime.r_count = 64'h0000_0001_FFFF_FFFF;
    #1 release dut.g_uptime.u_uptime.r_count;
    m_cnt = 64'h0000_0001_FFFF_FFFF;
    step(1'b1, 1'b1, 1'b0, 3'd2, 32'h0);
    check("carry_lo", readdata, 32'hFFFF_FFFF);
    repeat (3) step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd3, 32'h0);
    check("carry_hi_shadow", readdata, 32'h1);
`endif

    // Reset arriving behind a read discards it
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
    check("pre_reset_read", readdata, ID_V);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    check("reset_kills_rdv", 32'(readdatavalid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 3'd5, 32'h0);
    check("read_in_reset_rdv", 32'(readdatavalid), 32'h0);
    for (int a = 0; a < 8; a++) step(1'b1, 1'b1, 1'b0, 3'(a), 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd5, 32'h0);
    check("scratch0_after_reset", readdata, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd6, 32'h0);
    check("scratch1_after_reset", readdata, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd4, 32'h0);
    check("ctrl_after_reset", readdata, 32'h0);
    step(1'b1, 1'b1, 1'b0, 3'd7, 32'h0);
    check("unmapped7", readdata, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
           3'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
